crc_engine: RTL and testbench
=============================

CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 The block SHALL have parameter CRC_W, default 7: CRC width; legal range 3..32.
REQ-002 The block SHALL have parameter POLY, default 7'h09: generator polynomial without the implicit x^CRC_W term.
REQ-003 The block SHALL have parameter INIT, default 0: CRC register value loaded at reset and at START.
REQ-004 The block SHALL have port CLK, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port START, input, 1 bit: begin a frame.
REQ-007 The block SHALL have port MODE, input, 1 bit: 0 = generate, 1 = check; sampled only with START.
REQ-008 The block SHALL have port DIN, input, 1 bit: serial data bit, MSB-first.
REQ-009 The block SHALL have port DIN_VALID, input, 1 bit: DIN qualifier.
REQ-010 The block SHALL have port DIN_LAST, input, 1 bit: marks the final data bit; meaningful only with DIN_VALID.
REQ-011 The block SHALL have port DOUT, output, 1 bit: appended CRC bit, MSB-first.
REQ-012 The block SHALL have port DOUT_VALID, output, 1 bit: DOUT qualifier.
REQ-013 The block SHALL have port CRC, output, CRC_W bits: current CRC register.
REQ-014 The block SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port DONE, output, 1 bit: one-cycle end-of-frame pulse.
REQ-016 The block SHALL have port CRC_OK, output, 1 bit: check result.

Function
REQ-017 The FSM SHALL have states IDLE, DATA, APPEND, CHECK, plus a CRC_W-wide bit counter.
REQ-018 The update rule SHALL be: inv = DIN ^ CRC[CRC_W-1]; CRC <= {CRC[CRC_W-2:0],1'b0} ^ (inv ? POLY : 0); applied once per DIN_VALID cycle in DATA; the result is visible on CRC the next cycle.
REQ-019 In IDLE, START=1 SHALL load CRC=INIT, latch MODE, clear CRC_OK and the mismatch flag, and enter DATA; DIN_VALID in the same cycle SHALL be ignored.
REQ-020 In DATA, DIN_VALID=1 with DIN_LAST=1 SHALL include that bit and move to APPEND (MODE=0) or CHECK (MODE=1); DIN_LAST without DIN_VALID SHALL be ignored.
REQ-021 In APPEND, the block SHALL drive DOUT_VALID=1 for exactly CRC_W consecutive cycles, DOUT=CRC[CRC_W-1-n] for n=0..CRC_W-1, with no backpressure and CRC held constant; it SHALL then pulse DONE and go to IDLE.
REQ-022 In CHECK, each DIN_VALID bit n SHALL be compared with CRC[CRC_W-1-n]; any mismatch SHALL set a sticky flag, and CRC SHALL hold.
REQ-023 After the CRC_W-th check bit, the block SHALL pulse DONE, set CRC_OK = ~mismatch, and go to IDLE; CRC_OK SHALL hold until the next START or reset.
REQ-024 DONE SHALL assert in the cycle after the final APPEND/CHECK bit, for exactly one cycle, coincident with BUSY=0.
REQ-025 START in DATA, APPEND or CHECK SHALL abort the frame with no DONE and restart as in REQ-019.
REQ-026 DIN_VALID in IDLE or APPEND SHALL be ignored; a zero-length frame is not possible, since at least one data bit is required.
REQ-027 DIN_VALID gaps SHALL be permitted in DATA and CHECK without affecting the result.
REQ-028 CRC SHALL remain readable in IDLE after DONE until the next START.

Reset
REQ-029 RST SHALL force state=IDLE, CRC=INIT, counter=0, DOUT=0, DOUT_VALID=0, BUSY=0, DONE=0, CRC_OK=0, mismatch=0, latched MODE=0, immediately and independent of CLK.
REQ-030 RST during any state SHALL abandon the frame; the first START after deassertion SHALL behave as from power-up.

Configuration
REQ-031 With macro CRC_ENGINE_CHECK_EN defined, the CHECK state, mismatch flag and CRC_OK logic SHALL be present per REQ-022..023.
REQ-032 Without CRC_ENGINE_CHECK_EN, MODE SHALL be ignored (treated 0), CHECK SHALL be absent, and CRC_OK SHALL be tied 0; all other behaviour is unchanged.

Verification
REQ-033 With defaults, START, then single bit DIN=1 with LAST -> CRC=7'h09; APPEND emits 0,0,0,1,0,0,1; DONE one cycle later.
REQ-034 With defaults, MODE=0, frame 0x40,0x00,0x00,0x00,0x00 (40 bits) -> CRC=7'h4A; DOUT sequence 1001010; DONE=1 for exactly one cycle.
REQ-035 With CHECK_EN, MODE=1, the same 40 bits followed by 1001010 -> CRC_OK=1; repeat with the last check bit flipped -> CRC_OK=0.
REQ-036 With CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, ASCII "123456789" -> CRC=16'h29B1 with random DIN_VALID gaps.
REQ-037 RST asserted on the 3rd APPEND cycle -> DOUT_VALID=0, BUSY=0, CRC=INIT immediately, no DONE; START after RST in mid-DATA aborts and restarts with no DONE.

Source files
------------

// File: rtl/crc_engine_if.sv
// Bit-serial CRC engine bus: frame control and data in, appended CRC and status out.
// START/MODE/DIN* flow master->slave; everything else flows slave->master.
interface crc_engine_if #(
    parameter int CRC_W = 7
);
    // Valid-only handshake, no backpressure: DIN is consumed on every cycle
    // DIN_VALID is high, and DOUT must be taken on every cycle DOUT_VALID is high.
    logic             START;
    logic             MODE;
    logic             DIN;
    logic             DIN_VALID;
    logic             DIN_LAST;
    logic             DOUT;
    logic             DOUT_VALID;
    logic [CRC_W-1:0] CRC;
    logic             BUSY;
    logic             DONE;
    logic             CRC_OK;
    logic [1:0]       STATE;

    modport master (
        output START, MODE, DIN, DIN_VALID, DIN_LAST,
        input  DOUT, DOUT_VALID, CRC, BUSY, DONE, CRC_OK, STATE
    );

    modport slave (
        input  START, MODE, DIN, DIN_VALID, DIN_LAST,
        output DOUT, DOUT_VALID, CRC, BUSY, DONE, CRC_OK, STATE
    );
endinterface

// File: rtl/crc_engine.sv
// Bit-serial MSB-first CRC generator/checker with appended CRC output.
// Define CRC_ENGINE_CHECK_EN to include the CHECK state and CRC_OK result.
module crc_engine #(
    parameter int               CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY  = 7'h09,
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input logic        CLK,
    input logic        RST,
    crc_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, APPEND, CHECK} state_t;

    localparam int unsigned      LAST_I   = CRC_W - 1;
    localparam logic [CRC_W-1:0] CNT_LAST = LAST_I[CRC_W-1:0];

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             mode_in;
    logic             inv;
    logic [CRC_W-1:0] crc_next;
    logic [CRC_W-1:0] crc_shl;
    logic             tap;

    assign inv      = bus.DIN ^ crc_q[CRC_W-1];
    assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (inv ? POLY : '0);
    // Bit n of the held CRC, counted from the MSB, without a variable index.
    assign crc_shl  = crc_q << cnt_q;
    assign tap      = crc_shl[CRC_W-1];

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (bus.START) begin
            state_d = DATA;
            crc_d   = INIT;
            cnt_d   = '0;
            mode_d  = mode_in;
        end else begin
            case (state_q)
                IDLE: begin
                end
                DATA: begin
                    if (bus.DIN_VALID) begin
                        crc_d = crc_next;
                        if (bus.DIN_LAST) begin
                            cnt_d   = '0;
                            state_d = mode_q ? CHECK : APPEND;
                        end
                    end
                end
                APPEND: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
`ifdef CRC_ENGINE_CHECK_EN
                CHECK: begin
                    if (bus.DIN_VALID) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

`ifdef CRC_ENGINE_CHECK_EN
    logic mism_q, mism_d;
    logic ok_q, ok_d;
    logic bit_bad;

    assign bit_bad = bus.DIN ^ tap;

    // Mismatch is sticky for the frame; CRC_OK is only resolved on the last check bit.
    always_comb begin
        mism_d = mism_q;
        ok_d   = ok_q;
        if (bus.START) begin
            mism_d = 1'b0;
            ok_d   = 1'b0;
        end else if (state_q == CHECK && bus.DIN_VALID) begin
            mism_d = mism_q | bit_bad;
            if (cnt_q == CNT_LAST) ok_d = ~(mism_q | bit_bad);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mism_q <= 1'b0;
            ok_q   <= 1'b0;
        end else begin
            mism_q <= mism_d;
            ok_q   <= ok_d;
        end
    end

    assign mode_in    = bus.MODE;
    assign bus.CRC_OK = ok_q;
`else
    assign mode_in    = 1'b0;
    assign bus.CRC_OK = 1'b0;
`endif

    assign bus.DOUT_VALID = (state_q == APPEND);
    assign bus.DOUT       = (state_q == APPEND) & tap;
    assign bus.CRC        = crc_q;
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.DONE       = done_q;
    assign bus.STATE      = state_q;
endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: default CRC-7 instance plus a CRC-16/CCITT instance.
module tb_crc_engine;
    logic CLK;
    logic RST;
    int   total;
    int   bad;

    crc_engine_if #(.CRC_W(7))  b7 ();
    crc_engine_if #(.CRC_W(16)) b16 ();

    crc_engine u7 (
        .CLK (CLK),
        .RST (RST),
        .bus (b7)
    );

    crc_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) u16 (
        .CLK (CLK),
        .RST (RST),
        .bus (b16)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drivers for the 7-bit instance
    task automatic start7(input logic m);
        b7.START = 1'b1;
        b7.MODE  = m;
        tick();
        b7.START = 1'b0;
        b7.MODE  = 1'b0;
    endtask

    task automatic bit7(input logic d, input logic last);
        b7.DIN_VALID = 1'b1;
        b7.DIN       = d;
        b7.DIN_LAST  = last;
        tick();
        b7.DIN_VALID = 1'b0;
        b7.DIN_LAST  = 1'b0;
        b7.DIN       = 1'b0;
    endtask

    task automatic gap7();
        repeat ($urandom_range(0, 2)) begin
            b7.DIN_LAST = 1'b1;
            tick();
            b7.DIN_LAST = 1'b0;
        end
    endtask

    task automatic frame40(input logic gaps);
        logic [39:0] f;
        f = 40'h40_0000_0000;
        for (int i = 39; i >= 0; i--) begin
            if (gaps) gap7();
            bit7(f[i], i == 0);
        end
    endtask

    // scoreboard for the appended CRC stream
    task automatic expect_append(input string tag, input logic [6:0] e, input logic noise);
        logic [6:0] exp_q[$];
        for (int n = 6; n >= 0; n--) exp_q.push_back({6'd0, e[n]});
        for (int n = 0; n < 7; n++) begin
            logic [6:0] eb;
            eb = exp_q.pop_front();
            chk({tag, "_dv"},   b7.DOUT_VALID, 32'd1);
            chk({tag, "_dout"}, b7.DOUT,       eb);
            chk({tag, "_crc"},  b7.CRC,        e);
            chk({tag, "_nodn"}, b7.DONE,       32'd0);
            if (noise) begin
                b7.DIN_VALID = 1'b1;
                b7.DIN       = 1'($urandom_range(0, 1));
                b7.DIN_LAST  = 1'b1;
            end
            tick();
        end
        b7.DIN_VALID = 1'b0;
        b7.DIN_LAST  = 1'b0;
        b7.DIN       = 1'b0;
        chk({tag, "_done"},  b7.DONE,       32'd1);
        chk({tag, "_busy0"}, b7.BUSY,       32'd0);
        chk({tag, "_dv0"},   b7.DOUT_VALID, 32'd0);
        tick();
        chk({tag, "_done1c"}, b7.DONE, 32'd0);
        chk({tag, "_hold"},   b7.CRC,  e);
    endtask

    initial begin
        logic [71:0] s;
        logic [15:0] e16;
        total = 0;
        bad   = 0;
        RST = 1'b1;
        b7.START = 0;  b7.MODE = 0;  b7.DIN = 0;  b7.DIN_VALID = 0;  b7.DIN_LAST = 0;
        b16.START = 0; b16.MODE = 0; b16.DIN = 0; b16.DIN_VALID = 0; b16.DIN_LAST = 0;

        // reset state
        #3;
        chk("rst_busy",  b7.BUSY,       32'd0);
        chk("rst_done",  b7.DONE,       32'd0);
        chk("rst_dv",    b7.DOUT_VALID, 32'd0);
        chk("rst_dout",  b7.DOUT,       32'd0);
        chk("rst_crc",   b7.CRC,        32'h00);
        chk("rst_ok",    b7.CRC_OK,     32'd0);
        chk("rst_crc16", b16.CRC,       32'hFFFF);
        #3;
        RST = 1'b0;

        // single data bit 1 -> 0x09
        start7(1'b0);
        chk("a_busy", b7.BUSY, 32'd1);
        chk("a_init", b7.CRC,  32'h00);
        bit7(1'b1, 1'b1);
        expect_append("a", 7'h09, 1'b0);

        // DIN_VALID with START ignored, DIN_LAST without valid ignored, bits 1,0 -> 0x12
        b7.DIN_VALID = 1'b1;
        b7.DIN       = 1'b1;
        start7(1'b0);
        b7.DIN_VALID = 1'b0;
        b7.DIN       = 1'b0;
        chk("b_init", b7.CRC, 32'h00);
        b7.DIN_LAST = 1'b1;
        tick();
        b7.DIN_LAST = 1'b0;
        chk("b_lastnv_busy", b7.BUSY,       32'd1);
        chk("b_lastnv_dv",   b7.DOUT_VALID, 32'd0);
        bit7(1'b1, 1'b0);
        chk("b_crc1", b7.CRC, 32'h09);
        tick();
        bit7(1'b0, 1'b1);
        expect_append("b", 7'h12, 1'b0);

        // 40-bit frame with gaps, noise on DIN during APPEND
        start7(1'b0);
        frame40(1'b1);
        expect_append("c", 7'h4A, 1'b1);

`ifdef CRC_ENGINE_CHECK_EN
        // check mode: correct CRC then a corrupted last bit
        for (int pass = 0; pass < 2; pass++) begin
            logic [6:0] cb;
            cb = 7'b1001010 ^ 7'(pass);
            start7(1'b1);
            chk("d_ok_clr", b7.CRC_OK, 32'd0);
            frame40(1'b0);
            chk("d_state", b7.STATE,      32'd3);
            chk("d_dv",    b7.DOUT_VALID, 32'd0);
            for (int n = 6; n >= 0; n--) begin
                gap7();
                bit7(cb[n], 1'b0);
            end
            chk("d_done",  b7.DONE,   32'd1);
            chk("d_busy",  b7.BUSY,   32'd0);
            chk("d_crc",   b7.CRC,    32'h4A);
            chk("d_ok",    b7.CRC_OK, (pass == 0) ? 32'd1 : 32'd0);
            tick();
            chk("d_done1c", b7.DONE,   32'd0);
            chk("d_okhold", b7.CRC_OK, (pass == 0) ? 32'd1 : 32'd0);
        end
`else
        // MODE is ignored: a check request still generates
        start7(1'b1);
        frame40(1'b0);
        expect_append("d", 7'h4A, 1'b0);
        chk("d_ok_tied", b7.CRC_OK, 32'd0);
`endif

        // asynchronous reset on the 3rd APPEND cycle
        start7(1'b0);
        bit7(1'b1, 1'b1);
        tick();
        tick();
        chk("e_dv_pre", b7.DOUT_VALID, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("e_dv",   b7.DOUT_VALID, 32'd0);
        chk("e_busy", b7.BUSY,       32'd0);
        chk("e_crc",  b7.CRC,        32'h00);
        chk("e_done", b7.DONE,       32'd0);
        #2;
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("e_nodone", b7.DONE, 32'd0);
            chk("e_idle",   b7.BUSY, 32'd0);
        end
        start7(1'b0);
        bit7(1'b1, 1'b1);
        expect_append("e_after", 7'h09, 1'b0);

        // START in mid-DATA aborts and restarts without DONE
        start7(1'b0);
        bit7(1'b1, 1'b0);
        chk("f_crc1", b7.CRC, 32'h09);
        b7.DIN_VALID = 1'b1;
        b7.DIN       = 1'b1;
        b7.DIN_LAST  = 1'b1;
        start7(1'b0);
        b7.DIN_VALID = 1'b0;
        b7.DIN       = 1'b0;
        b7.DIN_LAST  = 1'b0;
        chk("f_restart", b7.CRC,  32'h00);
        chk("f_busy",    b7.BUSY, 32'd1);
        chk("f_nodone",  b7.DONE, 32'd0);
        bit7(1'b1, 1'b0);
        bit7(1'b0, 1'b1);
        expect_append("f", 7'h12, 1'b0);

        // CRC-16/CCITT over "123456789" with random gaps
        s   = "123456789";
        e16 = 16'h29B1;
        b16.START = 1'b1;
        tick();
        b16.START = 1'b0;
        chk("g_init", b16.CRC, 32'hFFFF);
        for (int i = 71; i >= 0; i--) begin
            repeat ($urandom_range(0, 2)) tick();
            b16.DIN_VALID = 1'b1;
            b16.DIN       = s[i];
            b16.DIN_LAST  = (i == 0);
            tick();
            b16.DIN_VALID = 1'b0;
            b16.DIN_LAST  = 1'b0;
        end
        chk("g_crc", b16.CRC, 32'h29B1);
        for (int n = 0; n < 16; n++) begin
            chk("g_dv",   b16.DOUT_VALID, 32'd1);
            chk("g_dout", b16.DOUT,       {31'd0, e16[15-n]});
            tick();
        end
        chk("g_done", b16.DONE, 32'd1);
        chk("g_busy", b16.BUSY, 32'd0);
        tick();
        chk("g_done1c", b16.DONE, 32'd0);
        chk("g_hold",   b16.CRC,  32'h29B1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
